// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle mini-CPU core and its run/halt controller.
package cpu_pkg;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;

  typedef enum logic [1:0] {
    StHalted,
    StRun,
    StStep,
    StDrain
  } ctrl_state_t;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer: gates the core clock-enable so the core only stops in FETCH,
// with a PC breakpoint checked at instruction boundaries and a retired-instruction counter.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W          = 8,
  parameter int unsigned CNT_W         = 16,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_req_i,
  input  logic             halt_req_i,
  input  logic             step_req_i,
  input  logic             bp_en_i,
  input  logic [PC_W-1:0]  bp_addr_i,
  input  logic [2:0]       core_state_i,
  input  logic [PC_W-1:0]  core_pc_i,
  output logic             core_en_o,
  output logic             halted_o,
  output logic             bp_hit_o,
  output logic [CNT_W-1:0] instr_count_o
);

  localparam ctrl_state_t ResetState = START_RUNNING ? StRun : StHalted;

  ctrl_state_t      state_q, state_d;
  logic             core_en_q, halted_q;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boundary, bp_match;

  // The core leaves WB on this edge; core_pc already points at the next instruction.
  assign boundary = core_en_q && (core_state_i == S_WB);
  assign bp_match = bp_en_i && (core_pc_i == bp_addr_i);

  always_comb begin
    state_d  = state_q;
    bp_hit_d = bp_hit_q;
    cnt_d    = boundary ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      StHalted: begin
        if (!halt_req_i) begin
          if (step_req_i) begin
            state_d  = StStep;
            bp_hit_d = 1'b0;
          end else if (run_req_i) begin
            state_d  = StRun;
            bp_hit_d = 1'b0;
          end
        end
      end
      StRun: begin
        if (boundary && bp_match) begin
          state_d  = StHalted;
          bp_hit_d = 1'b1;
        end else if (boundary && halt_req_i) begin
          state_d = StHalted;
        end else if (halt_req_i) begin
          state_d = StDrain;
        end
      end
      StStep: begin
        if (boundary) begin
          state_d = StHalted;
          if (bp_match) bp_hit_d = 1'b1;
        end
      end
      StDrain: begin
        if (boundary) begin
          state_d = StHalted;
          if (bp_match) bp_hit_d = 1'b1;
        end else if (run_req_i && !halt_req_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StHalted;
    endcase
  end

  // Outputs are registered from the next state so no input reaches core_en combinationally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ResetState;
      core_en_q <= (ResetState != StHalted);
      halted_q  <= (ResetState == StHalted);
      bp_hit_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      core_en_q <= (state_d != StHalted);
      halted_q  <= (state_d == StHalted);
      bp_hit_q  <= bp_hit_d;
      cnt_q     <= cnt_d;
    end
  end

  assign core_en_o     = core_en_q;
  assign halted_o      = halted_q;
  assign bp_hit_o      = bp_hit_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy core follows core_en, an instruction-level model predicts outputs.
module tb_cpu_run_ctrl;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'd0;
  logic [2:0] core_state;
  logic [7:0] core_pc;
  logic       core_en, halted, bp_hit;
  logic [15:0] instr_count;
  logic       core_en2, halted2, bp_hit2;
  logic [1:0] instr_count2;

  int total = 0;
  int bad = 0;

  // Model state: is the core allowed to run, stop after this instruction, halt pending.
  bit m_en, m_step, m_pend, m_bp;
  int m_cnt;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_W(8), .CNT_W(16), .START_RUNNING(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_req_i(run_req), .halt_req_i(halt_req),
    .step_req_i(step_req), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .core_state_i(core_state),
    .core_pc_i(core_pc), .core_en_o(core_en), .halted_o(halted), .bp_hit_o(bp_hit),
    .instr_count_o(instr_count)
  );

  cpu_run_ctrl #(.PC_W(8), .CNT_W(2), .START_RUNNING(1'b0)) dut_w2 (
    .clk_i(clk), .rst_ni(rst_n), .run_req_i(run_req), .halt_req_i(halt_req),
    .step_req_i(step_req), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .core_state_i(core_state),
    .core_pc_i(core_pc), .core_en_o(core_en2), .halted_o(halted2), .bp_hit_o(bp_hit2),
    .instr_count_o(instr_count2)
  );

  // Toy multicycle core: one state per enabled cycle, PC bumps as FETCH completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_state <= S_FETCH;
      core_pc    <= 8'd0;
    end else if (core_en) begin
      core_state <= (core_state == S_WB) ? S_FETCH : core_state + 3'd1;
      if (core_state == S_FETCH) core_pc <= core_pc + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("core_en", 32'(core_en), 32'(m_en));
    chk("halted", 32'(halted), 32'(!m_en));
    chk("bp_hit", 32'(bp_hit), 32'(m_bp));
    chk("instr_count", 32'(instr_count), m_cnt & 32'hFFFF);
    chk("instr_count_w2", 32'(instr_count2), m_cnt & 32'h3);
    chk("core_en_w2", 32'(core_en2), 32'(m_en));
    if (!m_en) chk("parked_fetch", 32'(core_state), 32'(S_FETCH));
  endtask

  // Instruction-level rules, evaluated with the values present just before the clock edge.
  task automatic model_step(input bit r, input bit h, input bit s);
    bit bnd;
    bnd = m_en && (core_state == S_WB);
    if (!m_en) begin
      if (!h && (s || r)) begin
        m_en   = 1'b1;
        m_step = s;
        m_bp   = 1'b0;
      end
    end else if (bnd) begin
      m_cnt++;
      if (bp_en && core_pc == bp_addr) begin
        m_en = 1'b0;
        m_bp = 1'b1;
      end else if (m_step || m_pend || h) begin
        m_en = 1'b0;
      end
      if (!m_en) begin
        m_step = 1'b0;
        m_pend = 1'b0;
      end
    end else if (!m_step) begin
      if (h) m_pend = 1'b1;
      else if (r) m_pend = 1'b0;
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic cyc(input bit r, input bit h, input bit s);
    run_req = r; halt_req = h; step_req = s;
    model_step(r, h, s);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    m_en = 1'b0; m_step = 1'b0; m_pend = 1'b0; m_bp = 1'b0; m_cnt = 0;
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] st);
    int n = 0;
    while (core_state != st && n < 20) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_state", 32'(core_state), 32'(st));
  endtask

  initial begin
    int n;
    logic [7:0] pc0;
    @(negedge clk);
    do_reset();

    // Idle while halted, then free-run: 20 enabled cycles retire 4 instructions.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("run20_count", 32'(instr_count), 32'd4);

    // Halt pulsed in DECODE drains for three more enabled cycles.
    wait_state(S_DECODE);
    cyc(1'b0, 1'b1, 1'b0);
    n = 0;
    while (core_en && n < 10) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("drain_len", n, 32'd3);

    // Single step: exactly five enabled cycles, one instruction, PC advances by one.
    pc0 = core_pc;
    cyc(1'b0, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (core_en) n++;
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("step_len", n, 32'd5);
    chk("step_pc", 32'(core_pc), 32'(pc0 + 8'd1));

    // Breakpoint at PC 2 from reset, then resume without re-hitting.
    do_reset();
    bp_en = 1'b1; bp_addr = 8'd2;
    cyc(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!halted && n < 50) begin
      cyc(1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("bp_pc", 32'(core_pc), 32'd2);
    chk("bp_flag", 32'(bp_hit), 32'd1);
    chk("bp_count", 32'(instr_count), 32'd2);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("bp_resume_count", 32'(instr_count), 32'd3);
    chk("bp_resume_running", 32'(halted), 32'd0);
    bp_en = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);

    // Simultaneous requests while halted, then halt landing exactly on a boundary.
    cyc(1'b1, 1'b1, 1'b0);
    chk("halt_beats_run", 32'(halted), 32'd1);
    pc0 = core_pc;
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("step_beats_run", 32'(core_pc), 32'(pc0 + 8'd1));
    cyc(1'b1, 1'b0, 1'b0);
    wait_state(S_WB);
    cyc(1'b0, 1'b1, 1'b0);
    chk("halt_on_boundary", 32'(halted), 32'd1);

    // Asynchronous reset in the middle of an instruction.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
    wait_state(S_EXECUTE);
    do_reset();

    // Randomised pulses, breakpoint moves and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = core_pc + 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 9) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
